opl2_host_if: RTL and testbench

OPL2_HOST_IF -- requirements
Module: opl2_host_if

---
 rtl/opl2_host_if_if.sv | 22 ++
 rtl/opl2_host_if.sv | 87 ++++++++
 tb/tb_opl2_host_if.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/opl2_host_if_if.sv
// Host bus bundle for the OPL2 host interface, plus the register-write
// command type shared by the block and its downstream stages.

typedef struct packed {
    logic       valid;
    logic [7:0] address;
    logic [7:0] data;
} opl2_reg_wr_t;

interface opl2_host_if_if;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       a0;
    logic [7:0] din;
    logic [7:0] dout;

    // Host side drives strobes and write data, receives read data.
    modport master (output cs_n, wr_n, rd_n, a0, din, input dout);
    // Chip side samples strobes and write data, returns read data.
    modport slave  (input cs_n, wr_n, rd_n, a0, din, output dout);
endinterface

// File: rtl/opl2_host_if.sv
// OPL2 host port: edge-detects host strobes, latches the register address,
// issues one register-write pulse per data write and enforces the chip's
// post-write wait time, flagging writes that arrive while busy.

module opl2_host_if #(
    parameter int ADDR_WAIT_CYCLES = 12,
    parameter int DATA_WAIT_CYCLES = 84
) (
    input  logic                clk,
    input  logic                reset_n,
    opl2_host_if_if.slave       host,
    input  logic [7:0]          status_in,
    output opl2_reg_wr_t        opl2_reg_wr,
    output logic                busy,
    output logic                overrun
);

    localparam int CNT_MAX = (ADDR_WAIT_CYCLES > DATA_WAIT_CYCLES) ?
                             ADDR_WAIT_CYCLES : DATA_WAIT_CYCLES;
    localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, ADDR_WAIT, DATA_WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    addr_q;
    // Previous combined strobe levels (1 = inactive). Reset forces 0 so a
    // strobe already low at reset release is not mistaken for a new access.
    logic          wr_prev;
    logic          rd_prev;

    logic wr_lvl, rd_lvl, wr_ev, rd_ev;

    assign wr_lvl = host.cs_n | host.wr_n;
    assign rd_lvl = host.cs_n | host.rd_n;
    assign wr_ev  = ~wr_lvl & wr_prev;
    assign rd_ev  = ~rd_lvl & rd_prev;

    // The counter is non-zero exactly while the FSM is in a wait state.
    assign busy = (state != IDLE);

    // Strobe history, wait FSM/counter, address latch, write command and read data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= 8'h00;
            wr_prev     <= 1'b0;
            rd_prev     <= 1'b0;
            opl2_reg_wr <= '0;
            overrun     <= 1'b0;
            host.dout   <= 8'h00;
        end else begin
            wr_prev           <= wr_lvl;
            rd_prev           <= rd_lvl;
            opl2_reg_wr.valid <= 1'b0;

            case (state)
                ADDR_WAIT, DATA_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= IDLE;
                end
                default: ;
            endcase

            // A write wins over a simultaneous read; the read is simply lost.
            if (wr_ev) begin
                if (busy) begin
                    overrun <= 1'b1;
                end else if (!host.a0) begin
                    addr_q <= host.din;
                    cnt    <= CW'(ADDR_WAIT_CYCLES);
                    state  <= (ADDR_WAIT_CYCLES == 0) ? IDLE : ADDR_WAIT;
                end else begin
                    cnt                 <= CW'(DATA_WAIT_CYCLES);
                    state               <= (DATA_WAIT_CYCLES == 0) ? IDLE : DATA_WAIT;
                    opl2_reg_wr.valid   <= 1'b1;
                    opl2_reg_wr.address <= addr_q;
                    opl2_reg_wr.data    <= host.din;
                end
            end else if (rd_ev) begin
                host.dout <= host.a0 ? 8'hFF : status_in;
            end
        end
    end

endmodule

// File: tb/tb_opl2_host_if.sv
// Bench for opl2_host_if: directed scenarios from the requirements plus a
// randomized run checked against a cycle-count based reference model.

module tb_opl2_host_if;

    localparam int AW = 12;
    localparam int DW = 84;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [7:0]   status_in;
    opl2_reg_wr_t opl2_reg_wr;
    logic         busy;
    logic         overrun;

    opl2_host_if_if bus();

    opl2_host_if #(.ADDR_WAIT_CYCLES(AW), .DATA_WAIT_CYCLES(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .host        (bus.slave),
        .status_in   (status_in),
        .opl2_reg_wr (opl2_reg_wr),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: busy is "current cycle <= end of last accepted wait".
    int           cyc = 0;
    int           m_busy_end = -1;
    logic [7:0]   m_addr = 8'h00;
    logic [7:0]   m_dout = 8'h00;
    logic         m_ov = 1'b0;
    opl2_reg_wr_t m_wr = '0;
    logic         m_prev_w = 1'b0;
    logic         m_prev_r = 1'b0;

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        logic wl, rl, we, re;
        wl = bus.cs_n | bus.wr_n;
        rl = bus.cs_n | bus.rd_n;
        if (!reset_n) begin
            m_prev_w = 1'b0; m_prev_r = 1'b0; m_busy_end = -1;
            m_addr = 8'h00; m_dout = 8'h00; m_ov = 1'b0; m_wr = '0;
        end else begin
            we = !wl && m_prev_w;
            re = !rl && m_prev_r;
            m_wr.valid = 1'b0;
            if (we) begin
                if (cyc <= m_busy_end) m_ov = 1'b1;
                else if (!bus.a0) begin
                    m_addr = bus.din; m_busy_end = cyc + AW;
                end else begin
                    m_busy_end = cyc + DW;
                    m_wr.valid = 1'b1; m_wr.address = m_addr; m_wr.data = bus.din;
                end
            end else if (re) begin
                m_dout = bus.a0 ? 8'hFF : status_in;
            end
            m_prev_w = wl; m_prev_r = rl;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle_bus();
        bus.cs_n = 1'b1; bus.wr_n = 1'b1; bus.rd_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; idle_bus(); bus.a0 = 1'b0; bus.din = 8'h00; status_in = 8'h00;
        tick(); tick();
        nvec++; if (opl2_reg_wr !== '0) begin nerr++; $display("FAIL reset_wr got %h want 0", opl2_reg_wr); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL reset_overrun got %b want 0", overrun); end
        nvec++; if (bus.dout !== 8'h00) begin nerr++; $display("FAIL reset_dout got %h want 00", bus.dout); end
        reset_n = 1'b1; tick();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    // Address write then data write once the address wait expires.
    task automatic test_addr_data();
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = 1'b0; bus.din = 8'h04;
        tick();                                   // now t0+1
        idle_bus();
        for (int k = 1; k <= 12; k++) begin
            nvec++; if (busy !== 1'b1 || opl2_reg_wr.valid !== 1'b0) begin
                nerr++; $display("FAIL addr_wait t0+%0d busy=%b valid=%b want 1/0", k, busy, opl2_reg_wr.valid); end
            tick();
        end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL addr_wait_end busy=%b want 0", busy); end
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = 1'b1; bus.din = 8'h80;
        tick();                                   // t0+14
        idle_bus();
        nvec++; if (opl2_reg_wr !== {1'b1, 8'h04, 8'h80} || busy !== 1'b1) begin
            nerr++; $display("FAIL data_pulse got %h busy=%b want 10480 busy=1", opl2_reg_wr, busy); end
        tick();                                   // t0+15
        nvec++; if (opl2_reg_wr !== {1'b0, 8'h04, 8'h80}) begin
            nerr++; $display("FAIL pulse_single got %h want 00480", opl2_reg_wr); end
        for (int k = 15; k <= 97; k++) begin
            nvec++; if (busy !== 1'b1 || opl2_reg_wr.valid !== 1'b0) begin
                nerr++; $display("FAIL data_wait t0+%0d busy=%b valid=%b want 1/0", k, busy, opl2_reg_wr.valid); end
            tick();
        end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL data_wait_end busy=%b want 0", busy); end
    endtask

    // Data write dropped in the middle of a data wait.
    task automatic test_overrun();
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = 1'b1; bus.din = 8'h55;
        tick(); idle_bus();                       // t0+1
        repeat (39) tick();                       // t0+40
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = 1'b1; bus.din = 8'hAA;
        tick(); idle_bus();                       // t0+41
        nvec++; if (opl2_reg_wr !== {1'b0, 8'h04, 8'h55} || overrun !== 1'b1) begin
            nerr++; $display("FAIL overrun_drop wr=%h ov=%b want 00455 ov=1", opl2_reg_wr, overrun); end
        repeat (43) tick();                       // t0+84
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL overrun_cnt_84 busy=%b want 1", busy); end
        tick();                                   // t0+85
        nvec++; if (busy !== 1'b0 || overrun !== 1'b1) begin
            nerr++; $display("FAIL overrun_cnt_85 busy=%b ov=%b want 0/1", busy, overrun); end
    endtask

    task automatic test_read();
        status_in = 8'hE0; bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.a0 = 1'b0;
        tick(); idle_bus(); status_in = 8'h12;
        nvec++; if (bus.dout !== 8'hE0) begin nerr++; $display("FAIL read_status got %h want E0", bus.dout); end
        repeat (3) tick();
        nvec++; if (bus.dout !== 8'hE0) begin nerr++; $display("FAIL read_hold got %h want E0", bus.dout); end
        bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.a0 = 1'b1;
        tick(); idle_bus();
        nvec++; if (bus.dout !== 8'hFF) begin nerr++; $display("FAIL read_data_port got %h want FF", bus.dout); end
    endtask

    // Held strobe gives one write; write+read in one cycle ignores the read.
    task automatic test_held_strobe();
        int pulses = 0;
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = 1'b1; bus.din = 8'h33;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (opl2_reg_wr.valid === 1'b1) pulses++;
        end
        idle_bus();
        nvec++; if (pulses != 1) begin nerr++; $display("FAIL held_strobe pulses=%0d want 1", pulses); end
        repeat (DW) tick();
        status_in = 8'h5A;
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.rd_n = 1'b0; bus.a0 = 1'b0; bus.din = 8'h07;
        tick(); idle_bus();
        nvec++; if (bus.dout !== 8'hFF || busy !== 1'b1) begin
            nerr++; $display("FAIL wr_rd_collide dout=%h busy=%b want FF/1", bus.dout, busy); end
        repeat (AW) tick();
    endtask

    // Reset in the middle of a data wait with the write strobe held low.
    task automatic test_reset_mid();
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = 1'b1; bus.din = 8'h11;
        tick(); idle_bus();                       // t0+1
        repeat (4) tick();                        // t0+5
        bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.a0 = 1'b1; bus.din = 8'h22;
        tick(); idle_bus();                       // read while busy
        nvec++; if (bus.dout !== 8'hFF) begin nerr++; $display("FAIL read_while_busy got %h want FF", bus.dout); end
        repeat (3) tick();                        // t0+9
        bus.cs_n = 1'b0; bus.wr_n = 1'b0;
        tick(); idle_bus();                       // dropped write -> overrun
        repeat (10) tick();                       // t0+20
        reset_n = 1'b0; bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = 1'b1; bus.din = 8'h66;
        tick();                                   // t0+21
        nvec++; if (busy !== 1'b0 || overrun !== 1'b0 || bus.dout !== 8'h00 || opl2_reg_wr.valid !== 1'b0) begin
            nerr++; $display("FAIL reset_mid busy=%b ov=%b dout=%h valid=%b want 0/0/00/0",
                             busy, overrun, bus.dout, opl2_reg_wr.valid); end
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            nvec++; if (opl2_reg_wr.valid !== 1'b0 || busy !== 1'b0) begin
                nerr++; $display("FAIL held_across_reset k=%0d valid=%b busy=%b want 0/0", k, opl2_reg_wr.valid, busy); end
        end
        bus.wr_n = 1'b1; tick();
        bus.wr_n = 1'b0; tick(); idle_bus();
        nvec++; if (opl2_reg_wr !== {1'b1, 8'h00, 8'h66} || busy !== 1'b1) begin
            nerr++; $display("FAIL write_after_reset got %h busy=%b want 10066/1", opl2_reg_wr, busy); end
        repeat (DW) tick();
    endtask

    // Randomized traffic compared against the model every cycle.
    task automatic test_random();
        for (int n = 0; n < 4000; n++) begin
            reset_n   = ($urandom_range(0, 399) != 0);
            bus.cs_n  = ($urandom_range(0, 3) == 0);
            bus.wr_n  = ($urandom_range(0, 5) != 0);
            bus.rd_n  = ($urandom_range(0, 2) != 0);
            bus.a0    = $urandom_range(0, 1);
            bus.din   = 8'($urandom);
            status_in = 8'($urandom);
            tick();
            nvec++;
            if (opl2_reg_wr !== m_wr || busy !== (cyc <= m_busy_end) ||
                overrun !== m_ov || bus.dout !== m_dout) begin
                nerr++;
                $display("FAIL random cyc=%0d wr=%h/%h busy=%b/%b ov=%b/%b dout=%h/%h (got/want)",
                         cyc, opl2_reg_wr, m_wr, busy, (cyc <= m_busy_end), overrun, m_ov, bus.dout, m_dout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addr_data();
        test_overrun();
        test_read();
        test_held_strobe();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
